ternary_neuron_seq: RTL and testbench
=====================================

TERNARY_NEURON_SEQ -- requirements
Module: ternary_neuron_seq

Interface
REQ-001 SHALL have parameter N_IN, default 8, number of input/weight pairs per evaluation (2..256).
REQ-002 SHALL have parameter IN_W, default 8, signed input sample width.
REQ-003 SHALL have parameter OUT_W, default 8, signed output width.
REQ-004 SHALL derive localparams ACC_W = IN_W + clog2(N_IN) + 1 and IDX_W = clog2(N_IN).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port w_we  input  1  weight write strobe.
REQ-008 SHALL have port w_addr  input  IDX_W  weight index.
REQ-009 SHALL have port w_data  input  2  ternary crumb: 01 = +1, 11 = -1, 00/10 = 0.
REQ-010 SHALL have port in_valid  input  1  sample valid.
REQ-011 SHALL have port in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-012 SHALL have port in_data  input  IN_W  signed sample.
REQ-013 SHALL have port abort  input  1  synchronous discard of the evaluation in progress.
REQ-014 SHALL have port out_valid  output  1  result valid.
REQ-015 SHALL have port out_ready  input  1  downstream accept.
REQ-016 SHALL have port out_data  output  OUT_W  signed saturated result.
REQ-017 SHALL have port busy  output  1  high when idx != 0 or in state DONE.

Function
REQ-018 SHALL hold N_IN 2-bit weight registers; w_we writes w_data to w_addr on the clock edge, in any state; addresses >= N_IN are ignored.
REQ-019 SHALL implement states ACC and DONE.
REQ-020 In ACC: in_ready = 1; on each accepted beat, acc += in_data (crumb 01), acc -= in_data (crumb 11), or acc unchanged (00/10), using weight[idx], and idx increments.
REQ-021 A beat whose weight address is written in the same cycle SHALL use the pre-write weight value.
REQ-022 On the beat where idx = N_IN-1, the FSM SHALL go to DONE, idx wraps to 0, and out_valid is high on the following cycle (latency 1 after the last beat).
REQ-023 In DONE: in_ready = 0, out_valid = 1, and out_data holds stable until out_ready = 1; then acc clears to 0 and the FSM returns to ACC.
REQ-024 out_data SHALL be acc clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; acc itself never overflows (width ACC_W, sign-extended input).
REQ-025 abort SHALL force acc = 0, idx = 0 and state ACC next cycle, taking priority over beat acceptance and the output handshake; weights are unaffected.
REQ-026 out_valid SHALL never be high in ACC; in_ready SHALL never be high in DONE.

Reset
REQ-027 Asserting reset (low) SHALL asynchronously set state = ACC, acc = 0, idx = 0, all weights = 00, out_valid = 0 and out_data = 0.
REQ-028 in_ready SHALL be 0 while reset is low and SHALL become 1 on the first clk edge after reset deasserts.

Configuration
REQ-029 With macro TERNARY_NEURON_RELU_EN defined, out_data SHALL be 0 whenever the clamped result is negative; positive results are unchanged.
REQ-030 Without TERNARY_NEURON_RELU_EN, out_data SHALL be the signed clamped result (REQ-024).

Verification
REQ-031 Weights all 01, N_IN=8, inputs 1..8 -> out_valid one cycle after the 8th beat, out_data = 36.
REQ-032 Weights alternating 01/11, inputs all 100 -> out_data = 0; weights all 11, inputs all 100 -> out_data = -128 (saturation), or 0 with RELU_EN.
REQ-033 Hold out_ready low 5 cycles in DONE with in_valid high -> in_ready = 0 and out_data stable; no beats consumed; next evaluation starts cleanly after out_ready = 1.
REQ-034 abort after 3 beats, then 8 beats of 1 with weights 01 -> out_data = 8.
REQ-035 Write weight[2] = 11 in the same cycle as beat 2 (old value 01) -> beat 2 is added; the next evaluation subtracts at index 2.
REQ-036 Assert reset low mid-evaluation, asynchronous to clk -> outputs clear immediately, weights read 0, first post-reset evaluation gives out_data = 0.

Source files
------------

// File: rtl/ternary_neuron_seq.sv
// rtl/ternary_neuron_seq.sv - sequential ternary-weight neuron: streams N_IN samples, emits a saturated sum.
// Optional macro TERNARY_NEURON_RELU_EN clamps negative results to zero.
module ternary_neuron_seq #(
    parameter  int N_IN  = 8,
    parameter  int IN_W  = 8,
    parameter  int OUT_W = 8,
    localparam int IDX_W = $clog2(N_IN),
    localparam int ACC_W = IN_W + $clog2(N_IN) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    w_we,
    input  logic [IDX_W-1:0]        w_addr,
    input  logic [1:0]              w_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    abort,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    busy
);

    localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {ACC, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [1:0]               weights [N_IN];
    logic                     started_q;
    logic                     load_out;
    logic                     accept;
    logic                     last_beat;
    logic [1:0]               weight_cur;
    logic signed [ACC_W-1:0]  in_ext;
    logic signed [CMP_W-1:0]  acc_x;
    logic signed [OUT_W-1:0]  result;

    // started_q keeps in_ready low until the first edge after reset release
    assign in_ready   = started_q && (state_q == ACC);
    assign out_valid  = (state_q == DONE);
    assign busy       = (idx_q != '0) || (state_q == DONE);
    assign accept     = in_valid && in_ready && !abort;
    assign last_beat  = (idx_q == IDX_W'(N_IN - 1));
    assign weight_cur = weights[idx_q];
    assign in_ext     = ACC_W'(in_data);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        load_out = 1'b0;
        if (abort) begin
            state_d = ACC;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        case (weight_cur)
                            2'b01:   acc_d = acc_q + in_ext;
                            2'b11:   acc_d = acc_q - in_ext;
                            default: acc_d = acc_q;
                        endcase
                        if (last_beat) begin
                            idx_d    = '0;
                            state_d  = DONE;
                            load_out = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    // Saturate the final sum that is about to be captured into out_data
    assign acc_x = CMP_W'(acc_d);

    always_comb begin
        result = '0;
        if (acc_x > SAT_MAX) begin
            result = SAT_MAX[OUT_W-1:0];
        end else if (acc_x < SAT_MIN) begin
            result = SAT_MIN[OUT_W-1:0];
        end else begin
            result = acc_x[OUT_W-1:0];
        end
`ifdef TERNARY_NEURON_RELU_EN
        if (result < 0) begin
            result = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ACC;
            acc_q     <= '0;
            idx_q     <= '0;
            started_q <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            started_q <= 1'b1;
            if (load_out) begin
                out_data <= result;
            end
        end
    end

    // Non-blocking write means a beat in the same cycle reads the old weight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                weights[i] <= 2'b00;
            end
        end else if (w_we && ({{(32-IDX_W){1'b0}}, w_addr} < 32'(N_IN))) begin
            weights[w_addr] <= w_data;
        end
    end

endmodule

// File: tb/tb_ternary_neuron_seq.sv
// tb/tb_ternary_neuron_seq.sv - directed self-checking bench for ternary_neuron_seq.
module tb_ternary_neuron_seq;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              w_we = 1'b0;
    logic [2:0]        w_addr = '0;
    logic [1:0]        w_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_data = '0;
    logic              abort = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] out_data;
    logic              busy;

    int tests = 0;
    int fails = 0;

`ifdef TERNARY_NEURON_RELU_EN
    localparam logic [7:0] EXP_NEG_SAT = 8'h00;
    localparam logic [7:0] EXP_NEG_24  = 8'h00;
`else
    localparam logic [7:0] EXP_NEG_SAT = 8'h80;
    localparam logic [7:0] EXP_NEG_24  = 8'hE8;
`endif

    ternary_neuron_seq dut (
        .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_weights(input logic [15:0] wpack);
        for (int i = 0; i < 8; i++) begin
            w_we = 1'b1; w_addr = 3'(i); w_data = wpack[2*i +: 2];
            @(posedge clk); #1;
        end
        w_we = 1'b0;
    endtask

    task automatic send_beat(input logic signed [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin
            tests++; fails++;
            $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic feed(input logic [63:0] dpack);
        for (int i = 0; i < 8; i++) send_beat(dpack[8*i +: 8]);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        tests++; if (out_data !== 8'd0) begin fails++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        @(negedge clk); reset = 1'b1; #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_release_in_ready got=%0b exp=0", in_ready); end
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL first_edge_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_sum();
        set_weights(16'h5555);
        for (int i = 1; i <= 7; i++) send_beat(8'(i));
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sum_early_valid got=%0b exp=0", out_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sum_busy got=%0b exp=1", busy); end
        send_beat(8'd8);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sum_valid got=%0b exp=1", out_valid); end
        tests++; if (out_data !== 8'd36) begin fails++; $display("FAIL sum_data got=%0d exp=36", out_data); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL sum_in_ready got=%0b exp=0", in_ready); end
        consume();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sum_release_valid got=%0b exp=0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sum_release_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_patterns();
        // weights +1,0(10),0(00),+1,-1,+1,0(10),+1 on inputs 1..8 -> 1+4-5+6+8 = 14
        set_weights(16'b01_10_01_11_01_00_10_01);
        feed(64'h0807060504030201);
        tests++; if (out_data !== 8'd14) begin fails++; $display("FAIL mixed_data got=%0d exp=14", out_data); end
        consume();
        set_weights(16'b11_01_11_01_11_01_11_01);
        feed({8{8'd100}});
        tests++; if (out_data !== 8'd0) begin fails++; $display("FAIL alt_data got=%0d exp=0", out_data); end
        consume();
        set_weights(16'hFFFF);
        feed({8{8'd100}});
        tests++; if (out_data !== EXP_NEG_SAT) begin fails++; $display("FAIL neg_sat got=%0d exp=%0d", out_data, $signed(EXP_NEG_SAT)); end
        consume();
        set_weights(16'h5555);
        feed({8{8'd100}});
        tests++; if (out_data !== 8'd127) begin fails++; $display("FAIL pos_sat got=%0d exp=127", out_data); end
        consume();
        feed({8{8'hFD}});
        tests++; if (out_data !== EXP_NEG_24) begin fails++; $display("FAIL neg_input got=%0d exp=%0d", out_data, $signed(EXP_NEG_24)); end
        consume();
    endtask

    task automatic test_backpressure();
        feed({8{8'd3}});
        in_valid = 1'b1; in_data = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
            tests++; if (out_data !== 8'd24 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold cyc=%0d got=%0d/%0b exp=24/1", i, out_data, out_valid); end
        end
        in_valid = 1'b0;
        consume();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_release_busy got=%0b exp=0", busy); end
        feed({8{8'd2}});
        tests++; if (out_data !== 8'd16) begin fails++; $display("FAIL bp_next_data got=%0d exp=16", out_data); end
        consume();
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) send_beat(8'd5);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_pre_busy got=%0b exp=1", busy); end
        abort = 1'b1; in_valid = 1'b1; in_data = 8'd5;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL abort_clear got=%0b/%0b exp=0/0", busy, out_valid); end
        feed({8{8'd1}});
        tests++; if (out_data !== 8'd8) begin fails++; $display("FAIL abort_data got=%0d exp=8", out_data); end
        consume();
    endtask

    task automatic test_back_to_back_weight_write();
        send_beat(8'd10);
        send_beat(8'd10);
        in_valid = 1'b1; in_data = 8'd10; w_we = 1'b1; w_addr = 3'd2; w_data = 2'b11;
        @(posedge clk); #1;
        in_valid = 1'b0; w_we = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(8'd10);
        tests++; if (out_data !== 8'd80) begin fails++; $display("FAIL race_old_weight got=%0d exp=80", out_data); end
        consume();
        feed({8{8'd10}});
        tests++; if (out_data !== 8'd60) begin fails++; $display("FAIL race_new_weight got=%0d exp=60", out_data); end
        consume();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) send_beat(8'd4);
        #3 reset = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL areset_clear got=%0b/%0b exp=0/0", in_ready, busy); end
        tests++; if (out_data !== 8'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL areset_out got=%0d/%0b exp=0/0", out_data, out_valid); end
        #7 reset = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL areset_release got=%0b exp=0", in_ready); end
        @(posedge clk); #1;
        feed({8{8'd7}});
        tests++; if (out_valid !== 1'b1 || out_data !== 8'd0) begin fails++; $display("FAIL areset_weights got=%0d/%0b exp=0/1", out_data, out_valid); end
        consume();
    endtask

    initial begin
        test_reset();
        test_sum();
        test_patterns();
        test_backpressure();
        test_abort();
        test_back_to_back_weight_write();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
